alpha_level_ctrl: RTL and testbench
===================================

Name: alpha_level_ctrl

Overview:
Streaming controller that sequences the per-pixel alpha level adjust datapath. It owns the alpha value applied to the datapath and changes it only at frame boundaries, optionally ramping from the current alpha toward a programmed target by a fixed step per frame (fade in/out). Pixels pass through one registered valid/ready stage. The controller also tracks frame framing (SOF/EOF) and reports protocol errors and ramp status.

Parameters:
RESET_ALPHA, 50, alpha applied after reset (50 = near-identity on the dark path)
ALPHA_MAX, 100, clamp ceiling for target and current alpha
FCNT_W, 16, width of frame counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
cfg_wr  in  1  one-cycle strobe, loads cfg_alpha/cfg_step into target registers
cfg_alpha  in  8  target alpha; values >ALPHA_MAX stored as ALPHA_MAX
cfg_step  in  8  per-frame ramp step; 0 = jump to target at next SOF
s_valid  in  1  input pixel valid
s_ready  out  1  input ready
s_pixel  in  8  input pixel
s_sof  in  1  first pixel of frame (qualified by s_valid)
s_eof  in  1  last pixel of frame (qualified by s_valid)
adj_pixel_o  out  8  pixel to the adjust datapath (= s_pixel)
adj_alpha_o  out  8  alpha to the adjust datapath (alpha_eff)
adj_pixel_i  in  8  result from the adjust datapath (combinational return)
m_valid  out  1  output valid
m_ready  in  1  output ready
m_pixel  out  8  adjusted pixel
m_sof  out  1  registered s_sof
m_eof  out  1  registered s_eof
ramp_busy  out  1  current alpha != target alpha
frame_cnt  out  FCNT_W  accepted-SOF count, wraps
err_sof  out  1  one-cycle pulse: SOF accepted while in frame
err_eof  out  1  one-cycle pulse: EOF accepted while idle

Behaviour:
- Reset (rst_n=0 at clk edge): cur_alpha=tgt_alpha=RESET_ALPHA, step=0, state IDLE, m_valid=0, m_pixel=0, m_sof=0, m_eof=0, frame_cnt=0, err pulses 0. Reset mid-frame drops the in-flight output beat; no partial state is retained.
- Handshake: accept = s_valid & s_ready; s_ready = !m_valid | m_ready. Output register loads on accept; m_valid clears when m_ready & !accept. Latency 1 cycle; full throughput at m_ready=1. m_* stable while m_valid & !m_ready.
- alpha_eff (combinational): if accept & s_sof then next_alpha else cur_alpha. The SOF beat itself uses the updated alpha.
- next_alpha: if cur==tgt: cur; if step==0: tgt; if tgt>cur: cur+min(step, tgt-cur); else cur-min(step, cur-tgt). No overshoot or wrap; the 9-bit intermediate is never truncated.
- cur_alpha <= next_alpha on every accepted SOF only. Alpha never changes mid-frame.
- cfg_wr: tgt_alpha <= min(cfg_alpha, ALPHA_MAX), step <= cfg_step. If cfg_wr coincides with an accepted SOF, that SOF uses the old target/step; the new values apply from the next SOF. A write during a ramp retargets from the current alpha.
- ramp_busy = (cur_alpha != tgt_alpha), registered-state derived.
- FSM IDLE/IN_FRAME:
  - IDLE + accepted SOF -> IN_FRAME (SOF&EOF on the same beat -> stays IDLE).
  - IN_FRAME + accepted EOF -> IDLE.
  - IN_FRAME + accepted SOF: err_sof pulse; treated as a new frame (alpha update, frame_cnt++).
  - IDLE + accepted EOF without SOF: err_eof pulse.
  - Non-SOF pixels in IDLE pass through with cur_alpha, no error.
- frame_cnt increments on each accepted SOF and wraps modulo 2^FCNT_W.
- m_pixel <= adj_pixel_i on accept. The datapath is combinational, so adj_pixel_i corresponds to the current adj_pixel_o/adj_alpha_o.

Test Plan:
- After reset, stream pixel 200 with SOF..EOF, m_ready=1 -> m_pixel=200 (alpha 50), 1-cycle latency, frame_cnt=1, ramp_busy=0.
- cfg_wr alpha=25 step=0, then frame of pixel 200 -> every beat including SOF m_pixel=100; adj_alpha_o stays 25 through EOF.
- cfg_wr alpha=100 step=20 from cur 50 -> successive frames use alpha 70, 90, 100, 100; ramp_busy drops after the third SOF; pixel 200 at alpha 100 -> 255.
- cfg_wr alpha=150 -> stored as 100. cfg_wr on the same cycle as an SOF accept -> that frame keeps the old alpha; the change lands at the next SOF.
- Backpressure: m_ready toggled 0/1 randomly across a 64-pixel frame -> no loss or duplication; m_* held while stalled; s_ready=0 only when m_valid & !m_ready.
- Protocol: SOF, SOF (no EOF) -> err_sof pulse, frame_cnt +2. EOF while idle -> err_eof pulse. Reset asserted mid-frame -> m_valid=0, alpha back to 50, state IDLE.

Source files
------------

// File: rtl/alpha_level_ctrl_if.sv
// Pixel stream link: valid/ready handshake carrying an 8-bit pixel with frame markers.
// The master drives the payload; the slave returns ready.
interface alpha_level_ctrl_if;
  logic       valid;
  logic       ready;
  logic [7:0] pixel;
  logic       sof;
  logic       eof;

  modport master (output valid, pixel, sof, eof, input ready);
  modport slave  (input valid, pixel, sof, eof, output ready);
endinterface

// File: rtl/alpha_level_ctrl.sv
// Alpha level controller: applies a frame-stable alpha to a combinational adjust datapath,
// ramps alpha toward a target once per frame, and registers the adjusted pixel stream.
module alpha_level_ctrl #(
  parameter int unsigned RESET_ALPHA = 50,
  parameter int unsigned ALPHA_MAX   = 100,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr,
  input  logic [7:0]          cfg_alpha,
  input  logic [7:0]          cfg_step,
  alpha_level_ctrl_if.slave   s,
  alpha_level_ctrl_if.master  m,
  output logic [7:0]          adj_pixel_o,
  output logic [7:0]          adj_alpha_o,
  input  logic [7:0]          adj_pixel_i,
  output logic                ramp_busy,
  output logic [FCNT_W-1:0]   frame_cnt,
  output logic                err_sof,
  output logic                err_eof
);

  localparam int unsigned AW = 8;

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cur_alpha, tgt_alpha, step;
  logic [AW-1:0] next_alpha;
  logic [AW:0]   delta, sum;
  logic          accept, sof_acc, eof_acc;
  logic          err_sof_nx, err_eof_nx;

  assign s.ready = !m.valid || m.ready;
  assign accept  = s.valid && s.ready;
  assign sof_acc = accept && s.sof;
  assign eof_acc = accept && s.eof;

  // One ramp step toward target, limited so it lands exactly on target.
  always_comb begin
    next_alpha = cur_alpha;
    delta      = '0;
    sum        = {1'b0, cur_alpha};
    if (cur_alpha == tgt_alpha) begin
      next_alpha = cur_alpha;
    end else if (step == '0) begin
      next_alpha = tgt_alpha;
    end else if (tgt_alpha > cur_alpha) begin
      delta = {1'b0, tgt_alpha} - {1'b0, cur_alpha};
      if ({1'b0, step} < delta) delta = {1'b0, step};
      sum        = {1'b0, cur_alpha} + delta;
      next_alpha = AW'(sum);
    end else begin
      delta = {1'b0, cur_alpha} - {1'b0, tgt_alpha};
      if ({1'b0, step} < delta) delta = {1'b0, step};
      sum        = {1'b0, cur_alpha} - delta;
      next_alpha = AW'(sum);
    end
  end

  assign adj_alpha_o = sof_acc ? next_alpha : cur_alpha;
  assign adj_pixel_o = s.pixel;
  assign ramp_busy   = (cur_alpha != tgt_alpha);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Framing: an SOF inside a frame restarts it, a bare EOF outside one is flagged.
  always_comb begin
    state_nx   = state;
    err_sof_nx = 1'b0;
    err_eof_nx = 1'b0;
    case (state)
      IDLE: begin
        if (sof_acc && !s.eof)      state_nx   = IN_FRAME;
        else if (eof_acc && !s.sof) err_eof_nx = 1'b1;
      end
      IN_FRAME: begin
        if (sof_acc) err_sof_nx = 1'b1;
        if (eof_acc) state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_alpha <= AW'(RESET_ALPHA);
      tgt_alpha <= AW'(RESET_ALPHA);
      step      <= '0;
      frame_cnt <= '0;
      err_sof   <= 1'b0;
      err_eof   <= 1'b0;
      m.valid   <= 1'b0;
      m.pixel   <= '0;
      m.sof     <= 1'b0;
      m.eof     <= 1'b0;
    end else begin
      err_sof <= err_sof_nx;
      err_eof <= err_eof_nx;
      if (cfg_wr) begin
        tgt_alpha <= (cfg_alpha > AW'(ALPHA_MAX)) ? AW'(ALPHA_MAX) : cfg_alpha;
        step      <= cfg_step;
      end
      if (sof_acc) begin
        cur_alpha <= next_alpha;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
      if (accept) begin
        m.valid <= 1'b1;
        m.pixel <= adj_pixel_i;
        m.sof   <= s.sof;
        m.eof   <= s.eof;
      end else if (m.ready) begin
        m.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alpha_level_ctrl.sv
// Directed bench for alpha_level_ctrl with a behavioural adjust datapath: out = min(255, pixel*alpha/50).
module tb_alpha_level_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr;
  logic [7:0]  cfg_alpha, cfg_step;
  logic [7:0]  adj_pixel_o, adj_alpha_o, adj_pixel_i;
  logic        ramp_busy, err_sof, err_eof;
  logic [15:0] frame_cnt;
  int          total = 0;
  int          bad   = 0;
  int          nsof  = 0;

  alpha_level_ctrl_if s_if();
  alpha_level_ctrl_if m_if();

  alpha_level_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_alpha(cfg_alpha), .cfg_step(cfg_step),
    .s(s_if), .m(m_if), .adj_pixel_o(adj_pixel_o), .adj_alpha_o(adj_alpha_o),
    .adj_pixel_i(adj_pixel_i), .ramp_busy(ramp_busy), .frame_cnt(frame_cnt),
    .err_sof(err_sof), .err_eof(err_eof)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_adj(input logic [7:0] p, input logic [7:0] a);
    int r;
    r = int'(p) * int'(a) / 50;
    return (r > 255) ? 8'd255 : 8'(r);
  endfunction

  assign adj_pixel_i = model_adj(adj_pixel_o, adj_alpha_o);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] p, input logic sof, input logic eof);
    s_if.valid = 1'b1; s_if.pixel = p; s_if.sof = sof; s_if.eof = eof;
    if (sof) nsof++;
  endtask

  task automatic idle_in;
    s_if.valid = 1'b0; s_if.sof = 1'b0; s_if.eof = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] a, input logic [7:0] st);
    cfg_wr = 1'b1; cfg_alpha = a; cfg_step = st;
    tick;
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_alpha = '0; cfg_step = '0;
    s_if.pixel = '0; idle_in; m_if.ready = 1'b1; nsof = 0;
    tick; tick;
    total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got %b want 0", m_if.valid); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    total++; if (adj_alpha_o !== 8'd50) begin bad++; $display("FAIL reset_alpha got %0d want 50", adj_alpha_o); end
    total++; if ({ramp_busy, err_sof, err_eof, m_if.sof, m_if.eof} !== 5'b0) begin bad++; $display("FAIL reset_flags got %b want 00000", {ramp_busy, err_sof, err_eof, m_if.sof, m_if.eof}); end
    total++; if (m_if.pixel !== 8'd0) begin bad++; $display("FAIL reset_m_pixel got %0d want 0", m_if.pixel); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_passthrough;
    put(8'd200, 1'b1, 1'b0); #1;
    total++; if (adj_alpha_o !== 8'd50) begin bad++; $display("FAIL pass_alpha got %0d want 50", adj_alpha_o); end
    tick;
    total++; if ({m_if.valid, m_if.sof, m_if.pixel} !== {1'b1, 1'b1, 8'd200}) begin bad++; $display("FAIL pass_sof_beat got v%b s%b %0d want v1 s1 200", m_if.valid, m_if.sof, m_if.pixel); end
    total++; if (frame_cnt !== 16'(nsof)) begin bad++; $display("FAIL pass_frame_cnt got %0d want %0d", frame_cnt, nsof); end
    put(8'd200, 1'b0, 1'b0); tick;
    put(8'd200, 1'b0, 1'b1); tick;
    total++; if ({m_if.valid, m_if.eof, m_if.pixel} !== {1'b1, 1'b1, 8'd200}) begin bad++; $display("FAIL pass_eof_beat got v%b e%b %0d want v1 e1 200", m_if.valid, m_if.eof, m_if.pixel); end
    idle_in; tick;
    total++; if ({m_if.valid, ramp_busy} !== 2'b00) begin bad++; $display("FAIL pass_drain got v%b busy%b want 00", m_if.valid, ramp_busy); end
  endtask

  task automatic test_jump;
    cfg(8'd25, 8'd0);
    total++; if (ramp_busy !== 1'b1) begin bad++; $display("FAIL jump_busy got %b want 1", ramp_busy); end
    for (int i = 0; i < 3; i++) begin
      put(8'd200, i == 0, i == 2); #1;
      total++; if (adj_alpha_o !== 8'd25) begin bad++; $display("FAIL jump_alpha beat %0d got %0d want 25", i, adj_alpha_o); end
      tick;
      total++; if (m_if.pixel !== 8'd100) begin bad++; $display("FAIL jump_pixel beat %0d got %0d want 100", i, m_if.pixel); end
    end
    idle_in; tick;
    total++; if (ramp_busy !== 1'b0) begin bad++; $display("FAIL jump_idle_busy got %b want 0", ramp_busy); end
  endtask

  task automatic test_ramp;
    logic [7:0] exp_a [4] = '{8'd70, 8'd90, 8'd100, 8'd100};
    logic       exp_b [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    cfg(8'd50, 8'd0);
    put(8'd50, 1'b1, 1'b1); tick; idle_in; tick;
    cfg(8'd100, 8'd20);
    total++; if (ramp_busy !== 1'b1) begin bad++; $display("FAIL ramp_start_busy got %b want 1", ramp_busy); end
    for (int k = 0; k < 4; k++) begin
      put(8'd50, 1'b1, 1'b1); #1;
      total++; if (adj_alpha_o !== exp_a[k]) begin bad++; $display("FAIL ramp_alpha frame %0d got %0d want %0d", k, adj_alpha_o, exp_a[k]); end
      tick;
      total++; if (m_if.pixel !== exp_a[k]) begin bad++; $display("FAIL ramp_pixel frame %0d got %0d want %0d", k, m_if.pixel, exp_a[k]); end
      total++; if (ramp_busy !== exp_b[k]) begin bad++; $display("FAIL ramp_busy frame %0d got %b want %b", k, ramp_busy, exp_b[k]); end
      idle_in; tick;
    end
    put(8'd200, 1'b1, 1'b1); tick;
    total++; if (m_if.pixel !== 8'd255) begin bad++; $display("FAIL ramp_sat got %0d want 255", m_if.pixel); end
    idle_in; tick;
  endtask

  task automatic test_clamp_coincide;
    cfg(8'd40, 8'd0);
    put(8'd50, 1'b1, 1'b1); tick; idle_in; tick;
    cfg(8'd150, 8'd0);
    total++; if (ramp_busy !== 1'b1) begin bad++; $display("FAIL clamp_busy got %b want 1", ramp_busy); end
    put(8'd50, 1'b1, 1'b1); #1;
    total++; if (adj_alpha_o !== 8'd100) begin bad++; $display("FAIL clamp_alpha got %0d want 100", adj_alpha_o); end
    tick;
    total++; if (ramp_busy !== 1'b0) begin bad++; $display("FAIL clamp_settled got %b want 0", ramp_busy); end
    cfg_wr = 1'b1; cfg_alpha = 8'd60; cfg_step = 8'd0;
    put(8'd50, 1'b1, 1'b1); #1;
    total++; if (adj_alpha_o !== 8'd100) begin bad++; $display("FAIL coincide_alpha got %0d want 100", adj_alpha_o); end
    tick; cfg_wr = 1'b0;
    total++; if ({m_if.pixel, ramp_busy} !== {8'd100, 1'b1}) begin bad++; $display("FAIL coincide_out got %0d busy%b want 100 busy1", m_if.pixel, ramp_busy); end
    put(8'd50, 1'b1, 1'b1); #1;
    total++; if (adj_alpha_o !== 8'd60) begin bad++; $display("FAIL coincide_next got %0d want 60", adj_alpha_o); end
    tick; idle_in; tick;
  endtask

  task automatic test_back_to_back;
    int tx = 0;
    int rx = 0;
    for (int cyc = 0; cyc < 600 && rx < 64; cyc++) begin
      m_if.ready = 1'($urandom_range(0, 1));
      if (tx < 64) begin
        s_if.valid = 1'b1; s_if.pixel = 8'(4 * tx + 3);
        s_if.sof = (tx == 0); s_if.eof = (tx == 63);
      end else begin
        idle_in;
      end
      #1;
      total++; if (s_if.ready !== (!m_if.valid || m_if.ready)) begin bad++; $display("FAIL bp_ready cyc %0d got %b want %b", cyc, s_if.ready, !m_if.valid || m_if.ready); end
      if (m_if.valid) begin
        total++; if ({m_if.pixel, m_if.sof, m_if.eof} !== {model_adj(8'(4 * rx + 3), 8'd60), rx == 0, rx == 63}) begin
          bad++; $display("FAIL bp_beat %0d got %0d s%b e%b want %0d", rx, m_if.pixel, m_if.sof, m_if.eof, model_adj(8'(4 * rx + 3), 8'd60));
        end
        if (m_if.ready) rx++;
      end
      if (s_if.valid && s_if.ready) begin
        if (tx == 0) nsof++;
        tx++;
      end
      tick;
    end
    idle_in; m_if.ready = 1'b1;
    total++; if (rx !== 64) begin bad++; $display("FAIL bp_count got %0d want 64", rx); end
    total++; if (m_if.valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got %b want 0", m_if.valid); end
    total++; if (frame_cnt !== 16'(nsof)) begin bad++; $display("FAIL bp_frame_cnt got %0d want %0d", frame_cnt, nsof); end
    tick;
  endtask

  task automatic test_protocol;
    put(8'd10, 1'b1, 1'b0); tick;
    total++; if (err_sof !== 1'b0) begin bad++; $display("FAIL proto_first_sof got %b want 0", err_sof); end
    put(8'd10, 1'b1, 1'b0); tick;
    total++; if (err_sof !== 1'b1) begin bad++; $display("FAIL proto_err_sof got %b want 1", err_sof); end
    total++; if (frame_cnt !== 16'(nsof)) begin bad++; $display("FAIL proto_frame_cnt got %0d want %0d", frame_cnt, nsof); end
    put(8'd10, 1'b0, 1'b1); tick;
    total++; if ({err_sof, err_eof} !== 2'b00) begin bad++; $display("FAIL proto_pulse_end got %b want 00", {err_sof, err_eof}); end
    put(8'd10, 1'b0, 1'b1); tick;
    total++; if (err_eof !== 1'b1) begin bad++; $display("FAIL proto_err_eof got %b want 1", err_eof); end
    idle_in; tick;
    total++; if (err_eof !== 1'b0) begin bad++; $display("FAIL proto_eof_clear got %b want 0", err_eof); end
    cfg(8'd20, 8'd0);
    put(8'd10, 1'b1, 1'b0); tick;
    m_if.ready = 1'b0; put(8'd10, 1'b0, 1'b0); #1;
    total++; if (s_if.ready !== 1'b0) begin bad++; $display("FAIL proto_stall got %b want 0", s_if.ready); end
    rst_n = 1'b0; tick; nsof = 0;
    idle_in; m_if.ready = 1'b1; #1;
    total++; if ({m_if.valid, ramp_busy, adj_alpha_o, frame_cnt} !== {1'b0, 1'b0, 8'd50, 16'd0}) begin
      bad++; $display("FAIL proto_mid_reset got v%b busy%b a%0d fc%0d want v0 busy0 a50 fc0", m_if.valid, ramp_busy, adj_alpha_o, frame_cnt);
    end
    rst_n = 1'b1; tick;
    put(8'd10, 1'b0, 1'b1); tick;
    total++; if (err_eof !== 1'b1) begin bad++; $display("FAIL proto_reset_idle got %b want 1", err_eof); end
    idle_in; tick;
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_jump;
    test_ramp;
    test_clamp_coincide;
    test_back_to_back;
    test_protocol;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
